// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, byte-lane masks,
// FSM states and the alignment/legality helpers used by the stage.
package mem_access_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [7:0] MASK_B = 8'h01;
   localparam logic [7:0] MASK_H = 8'h03;
   localparam logic [7:0] MASK_W = 8'h0F;
   localparam logic [7:0] MASK_D = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DONE
   } state_t;

   function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
      case (funct3)
         F3_H, F3_HU: is_aligned = ~addr_lo[0];
         F3_W, F3_WU: is_aligned = (addr_lo[1:0] == 2'b00);
         F3_D:        is_aligned = (addr_lo == 3'b000);
         default:     is_aligned = 1'b1;
      endcase
   endfunction

   function automatic logic [7:0] size_mask(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: size_mask = MASK_B;
         F3_H, F3_HU: size_mask = MASK_H;
         F3_W, F3_WU: size_mask = MASK_W;
         default:     size_mask = MASK_D;
      endcase
   endfunction

   // Stores only have the signed encodings; loads lack only 111.
   function automatic logic is_legal(input logic [2:0] funct3, input logic is_store);
      is_legal = is_store ? ~funct3[2] : (funct3 != 3'b111);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load extraction: selects the addressed field of a read doubleword and
// sign- or zero-extends it to 64 bits according to funct3.
module mem_load_align
   import mem_access_stage_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [2:0]  offset,
   output logic [63:0] value
);

   logic [63:0] field;

   always_comb begin
      field = rdata >> {offset, 3'b000};
      case (funct3)
         F3_B:    value = {{56{field[7]}},  field[7:0]};
         F3_H:    value = {{48{field[15]}}, field[15:0]};
         F3_W:    value = {{32{field[31]}}, field[31:0]};
         F3_BU:   value = {56'd0, field[7:0]};
         F3_HU:   value = {48'd0, field[15:0]};
         F3_WU:   value = {32'd0, field[31:0]};
         default: value = field;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs one req/ack transaction on the data-memory port
// per load/store, stalls the pipeline meanwhile, and returns aligned results.
module mem_access_stage
   import mem_access_stage_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [63:0] addr_i,
   input  logic [63:0] wdata_i,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wmask,
   input  logic        dmem_ack,
   input  logic [63:0] dmem_rdata,
   output logic [63:0] rdata_o,
   output logic [7:0]  wmask_o,
   output logic        stall_o,
   output logic        fault_o
);

   state_t      state, state_next;
   logic        access, fault, start;
   logic [2:0]  f3_q, off_q;
   logic [63:0] load_value;

   assign access = mem_read_i | mem_write_i;
   assign fault  = access & ((mem_read_i & mem_write_i)
                           | ~is_legal(funct3_i, mem_write_i)
                           | ~is_aligned(funct3_i, addr_i[2:0]));
   assign start  = (state == ST_IDLE) & access & ~fault;

   // Gated by nrst so a reset mid-transaction never freezes the pipeline.
   assign stall_o = nrst & (start | (state == ST_REQ));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_REQ;
         ST_REQ:  if (dmem_ack) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   mem_load_align u_load_align (
      .rdata  (dmem_rdata),
      .funct3 (f3_q),
      .offset (off_q),
      .value  (load_value)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wmask <= '0;
         rdata_o    <= '0;
         wmask_o    <= '0;
         fault_o    <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
      end else begin
         fault_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (access && fault) begin
                  fault_o <= 1'b1;
               end else if (start) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write_i;
                  dmem_addr  <= {addr_i[63:3], 3'b000};
                  dmem_wdata <= wdata_i << {addr_i[2:0], 3'b000};
                  dmem_wmask <= size_mask(funct3_i) << addr_i[2:0];
                  f3_q       <= funct3_i;
                  off_q      <= addr_i[2:0];
               end
            end
            ST_REQ: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) rdata_o <= load_value;
                  wmask_o <= dmem_we ? dmem_wmask : 8'h00;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
